mem_indirect_sequencer: RTL and testbench

//  Memory-stage access sequencer; successor to the fixed LDI/STI stall logic.

---
 rtl/mem_indirect_sequencer.sv | 147 ++++++++++++++
 tb/tb_mem_indirect_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_indirect_sequencer.sv
// Memory-stage access sequencer: direct or N-level indirect load/store over a
// mem_read/mem_write/mem_resp handshake, stalling the pipeline until complete.
module mem_indirect_sequencer #(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 16,
   parameter int MAX_INDIRECT = 2,
   parameter int LVL_WIDTH    = (MAX_INDIRECT > 0) ? $clog2(MAX_INDIRECT + 1) : 1,
   parameter bit ALIGN_PTR    = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   input  logic                  req_read,
   input  logic                  req_write,
   input  logic [LVL_WIDTH-1:0]  req_indirect,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic                  mem_resp,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  load_pipeline,
   output logic                  done,
   output logic                  err
);

   // state  | meaning
   // IDLE   | waiting for a MEM-stage load/store, pipeline free to advance
   // PTR    | fetching the next pointer level from ptr_reg
   // ACCESS | performing the final load/store at ptr_reg
   // DONE   | one-cycle completion, pipeline released
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_PTR    = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [LVL_WIDTH-1:0] LVL_MAX  = LVL_WIDTH'(MAX_INDIRECT);
   localparam logic [LVL_WIDTH-1:0] LVL_ONE  = LVL_WIDTH'(1);
   localparam logic [LVL_WIDTH-1:0] LVL_ZERO = '0;

   logic [1:0]            state;
   logic [LVL_WIDTH-1:0]  cnt;
   logic [ADDR_WIDTH-1:0] ptr_reg;
   logic [DATA_WIDTH-1:0] wdata_reg;
   logic [DATA_WIDTH-1:0] rdata_reg;
   logic                  op_read;
   logic                  op_write;

   logic                  req_go;
   logic                  req_both;
   logic                  req_deep;
   logic [LVL_WIDTH-1:0]  lvl_start;
   logic [ADDR_WIDTH-1:0] ptr_fetched;

   assign req_go   = req_valid & (req_read | req_write);
   assign req_both = req_read & req_write;
   assign req_deep = (req_indirect > LVL_MAX);

   always_comb begin
      lvl_start = req_deep ? LVL_MAX : req_indirect;
   end

   // Fetched pointers are the low ADDR_WIDTH bits of the memory word.
   always_comb begin
      ptr_fetched = mem_rdata[ADDR_WIDTH-1:0];
      if (ALIGN_PTR) begin
         ptr_fetched[0] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         ptr_reg   <= '0;
         wdata_reg <= '0;
         rdata_reg <= '0;
         op_read   <= 1'b0;
         op_write  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_go) begin
                  // A read+write conflict resolves to a load.
                  op_read   <= req_read;
                  op_write  <= req_write & ~req_read;
                  ptr_reg   <= req_addr;
                  wdata_reg <= req_wdata;
                  cnt       <= lvl_start;
                  state     <= (lvl_start == LVL_ZERO) ? S_ACCESS : S_PTR;
               end
            end
            S_PTR: begin
               if (mem_resp) begin
                  ptr_reg <= ptr_fetched;
                  cnt     <= cnt - LVL_ONE;
                  state   <= (cnt == LVL_ONE) ? S_ACCESS : S_PTR;
               end
            end
            S_ACCESS: begin
               if (mem_resp) begin
                  if (op_read) begin
                     rdata_reg <= mem_rdata;
                  end
                  state <= S_DONE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      load_pipeline = 1'b0;
      done          = 1'b0;
      err           = 1'b0;
      case (state)
         S_IDLE: begin
            load_pipeline = ~req_go;
            err           = req_go & (req_both | req_deep);
         end
         S_PTR: begin
            mem_read = 1'b1;
         end
         S_ACCESS: begin
            mem_read  = op_read;
            mem_write = op_write;
         end
         default: begin
            done          = 1'b1;
            load_pipeline = 1'b1;
         end
      endcase
   end

   assign mem_address = ptr_reg;
   assign mem_wdata   = wdata_reg;
   assign rdata       = rdata_reg;

endmodule

// File: tb/tb_mem_indirect_sequencer.sv
// Directed bench for mem_indirect_sequencer with a behavioural memory that
// answers requests after a programmable number of wait cycles.
module tb_mem_indirect_sequencer;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_read;
   logic        req_write;
   logic [1:0]  req_indirect;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        mem_resp;
   logic [15:0] mem_rdata;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_address;
   logic [15:0] mem_wdata;
   logic [15:0] rdata;
   logic        load_pipeline;
   logic        done;
   logic        err;

   mem_indirect_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_read      (req_read),
      .req_write     (req_write),
      .req_indirect  (req_indirect),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .mem_resp      (mem_resp),
      .mem_rdata     (mem_rdata),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_address   (mem_address),
      .mem_wdata     (mem_wdata),
      .rdata         (rdata),
      .load_pipeline (load_pipeline),
      .done          (done),
      .err           (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory model: answers at the negedge so mem_resp is stable at posedge.
   logic [15:0] mem [logic [15:0]];
   int          wait_cfg = 0;
   int          wait_cnt = 0;
   logic        stray    = 1'b0;
   int          overlaps = 0;
   logic [15:0] log_addr [$];
   logic        log_wr   [$];
   logic [15:0] log_data [$];

   initial begin
      mem_resp  = 1'b0;
      mem_rdata = '0;
   end

   always @(negedge clk) begin
      if (mem_read && mem_write) overlaps++;
      if (mem_read || mem_write) begin
         if (wait_cnt >= wait_cfg) begin
            mem_resp = 1'b1;
            mem_rdata = mem.exists(mem_address) ? mem[mem_address] : 16'h0000;
            if (mem_write) mem[mem_address] = mem_wdata;
            log_addr.push_back(mem_address);
            log_wr.push_back(mem_write);
            log_data.push_back(mem_write ? mem_wdata : mem_rdata);
            wait_cnt = 0;
         end else begin
            mem_resp = 1'b0;
            wait_cnt++;
         end
      end else begin
         mem_resp = stray;
         mem_rdata = 16'hDEAD;
         wait_cnt = 0;
      end
   end

   int         done_cyc;
   logic       err_c1;
   logic       err_c2;
   logic [7:0] lp_hist;

   // Cycle 1 is the IDLE cycle that sees the request; counts to the done pulse.
   task automatic run_op(input logic rd, input logic wr, input logic [1:0] lvl,
                         input logic [15:0] addr, input logic [15:0] wd);
      int cyc;
      log_addr.delete();
      log_wr.delete();
      log_data.delete();
      @(negedge clk);
      req_valid    = 1'b1;
      req_read     = rd;
      req_write    = wr;
      req_indirect = lvl;
      req_addr     = addr;
      req_wdata    = wd;
      #1;
      cyc      = 1;
      err_c1   = err;
      err_c2   = 1'b0;
      lp_hist  = {7'd0, load_pipeline};
      done_cyc = 0;
      while (done_cyc == 0 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         lp_hist = {lp_hist[6:0], load_pipeline};
         if (done) done_cyc = cyc;
         if (cyc == 2) begin
            // Garbage on req_* after capture must be ignored.
            req_valid = 1'b0;
            req_addr  = 16'hFFFF;
            req_wdata = 16'h0BAD;
            #1;
            err_c2 = err;
         end
      end
      check_vec("op_finished", {31'd0, done_cyc != 0}, 32'd1);
   endtask

   initial begin
      rst_n        = 1'b0;
      req_valid    = 1'b0;
      req_read     = 1'b0;
      req_write    = 1'b0;
      req_indirect = '0;
      req_addr     = '0;
      req_wdata    = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_vec("rst_mem_read", {31'd0, mem_read}, 32'd0);
      check_vec("rst_mem_write", {31'd0, mem_write}, 32'd0);
      check_vec("rst_done", {31'd0, done}, 32'd0);
      check_vec("rst_lp", {31'd0, load_pipeline}, 32'd1);
      check_vec("rst_rdata", {16'd0, rdata}, 32'h0);

      // 1: direct load
      mem[16'h0040] = 16'hBEEF;
      wait_cfg = 0;
      run_op(1'b1, 1'b0, 2'd0, 16'h0040, 16'h0);
      check_vec("t1_done_cyc", done_cyc, 32'd3);
      check_vec("t1_rdata", {16'd0, rdata}, 32'hBEEF);
      check_vec("t1_n_acc", log_addr.size(), 32'd1);
      if (log_addr.size() >= 1) check_vec("t1_addr", {16'd0, log_addr[0]}, 32'h0040);
      check_vec("t1_lp_seq", {29'd0, lp_hist[2:0]}, 32'b001);
      check_vec("t1_err", {31'd0, err_c1}, 32'd0);

      // 2: LDI with pointer alignment
      mem[16'h0100] = 16'h2001;
      mem[16'h2000] = 16'hCAFE;
      run_op(1'b1, 1'b0, 2'd1, 16'h0100, 16'h0);
      check_vec("t2_done_cyc", done_cyc, 32'd4);
      check_vec("t2_n_acc", log_addr.size(), 32'd2);
      if (log_addr.size() >= 2) begin
         check_vec("t2_ptr_addr", {16'd0, log_addr[0]}, 32'h0100);
         check_vec("t2_acc_addr", {16'd0, log_addr[1]}, 32'h2000);
      end
      check_vec("t2_rdata", {16'd0, rdata}, 32'hCAFE);

      // 3: STI with two wait cycles per access
      mem[16'h0200] = 16'h3000;
      wait_cfg = 2;
      overlaps = 0;
      run_op(1'b0, 1'b1, 2'd1, 16'h0200, 16'h1234);
      check_vec("t3_done_cyc", done_cyc, 32'd8);
      check_vec("t3_n_acc", log_addr.size(), 32'd2);
      if (log_addr.size() >= 2) begin
         check_vec("t3_ptr_rd", {31'd0, log_wr[0]}, 32'd0);
         check_vec("t3_wr", {31'd0, log_wr[1]}, 32'd1);
         check_vec("t3_wr_addr", {16'd0, log_addr[1]}, 32'h3000);
         check_vec("t3_wr_data", {16'd0, log_data[1]}, 32'h1234);
      end
      check_vec("t3_mem", {16'd0, mem[16'h3000]}, 32'h1234);
      check_vec("t3_overlap", overlaps, 32'd0);
      check_vec("t3_rdata_hold", {16'd0, rdata}, 32'hCAFE);

      // 4: two-level chain
      mem[16'h0010] = 16'h0020;
      mem[16'h0020] = 16'h0030;
      mem[16'h0030] = 16'h5555;
      wait_cfg = 0;
      run_op(1'b1, 1'b0, 2'd2, 16'h0010, 16'h0);
      check_vec("t4_done_cyc", done_cyc, 32'd5);
      check_vec("t4_n_acc", log_addr.size(), 32'd3);
      if (log_addr.size() >= 3) begin
         check_vec("t4_a0", {16'd0, log_addr[0]}, 32'h0010);
         check_vec("t4_a1", {16'd0, log_addr[1]}, 32'h0020);
         check_vec("t4_a2", {16'd0, log_addr[2]}, 32'h0030);
      end
      check_vec("t4_rdata", {16'd0, rdata}, 32'h5555);

      // 5: read+write and too-deep indirection: err, clamped, load
      mem[16'h0050] = 16'h0061;
      mem[16'h0060] = 16'h0071;
      mem[16'h0070] = 16'h7777;
      run_op(1'b1, 1'b1, 2'd3, 16'h0050, 16'h9999);
      check_vec("t5_err", {31'd0, err_c1}, 32'd1);
      check_vec("t5_err_pulse", {31'd0, err_c2}, 32'd0);
      check_vec("t5_n_acc", log_addr.size(), 32'd3);
      if (log_addr.size() >= 3) begin
         check_vec("t5_a0", {16'd0, log_addr[0]}, 32'h0050);
         check_vec("t5_a1", {16'd0, log_addr[1]}, 32'h0060);
         check_vec("t5_a2", {16'd0, log_addr[2]}, 32'h0070);
         check_vec("t5_all_rd", {29'd0, log_wr[0], log_wr[1], log_wr[2]}, 32'd0);
      end
      check_vec("t5_rdata", {16'd0, rdata}, 32'h7777);
      check_vec("t5_mem_intact", {16'd0, mem[16'h0070]}, 32'h7777);

      // 6: reset during a pointer wait, then stray responses
      wait_cfg = 5;
      @(negedge clk);
      req_valid    = 1'b1;
      req_read     = 1'b1;
      req_write    = 1'b0;
      req_indirect = 2'd1;
      req_addr     = 16'h0100;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check_vec("t6_in_ptr", {31'd0, mem_read}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_vec("t6_abort_rd", {31'd0, mem_read}, 32'd0);
      check_vec("t6_abort_lp", {31'd0, load_pipeline}, 32'd1);
      check_vec("t6_rdata_clr", {16'd0, rdata}, 32'h0);
      stray = 1'b1;
      begin
         logic busy;
         busy = 1'b0;
         repeat (4) begin
            @(negedge clk);
            busy = busy | mem_read | mem_write | done;
         end
         check_vec("t6_stray_ign", {31'd0, busy}, 32'd0);
      end
      stray = 1'b0;
      check_vec("t6_rdata_kept", {16'd0, rdata}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
